// File: rtl/round_robin_dispatcher.sv
// Round-robin dispatcher: fans a single valid/ready stream out to NUM_OUT
// channels, each with its own one-entry output register. Items go to the
// next free channel in cyclic order starting from a rotation pointer.
module round_robin_dispatcher #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          allow_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [$clog2(NUM_OUT)-1:0]    sel_o,
    output logic [NUM_OUT*DATA_WIDTH-1:0] data_o,
    output logic [NUM_OUT-1:0]            valid_o,
    input  logic [NUM_OUT-1:0]            ready_i
);

    localparam int SEL_W = $clog2(NUM_OUT);

    logic [NUM_OUT-1:0]    full_q;
    logic [NUM_OUT-1:0]    full_d;
    logic [DATA_WIDTH-1:0] slotData_q [NUM_OUT];
    logic [DATA_WIDTH-1:0] slotData_d [NUM_OUT];
    logic [SEL_W-1:0]      ptr_q;
    logic [SEL_W-1:0]      ptr_d;

    logic [NUM_OUT-1:0]    freeMask;
    logic [SEL_W-1:0]      upperSel;
    logic [SEL_W-1:0]      lowerSel;
    logic                  upperFound;
    logic [SEL_W-1:0]      selIdx;
    logic                  fire;

    // A slot that is draining this cycle can be refilled in the same cycle.
    assign freeMask = ~full_q | ready_i;
    assign ready_o  = allow_i & (|freeMask);
    assign fire     = valid_i & ready_o;
    assign sel_o    = selIdx;
    assign valid_o  = full_q;

    // Cyclic search from ptr: lowest free slot at or above ptr, otherwise
    // wrap around to the lowest free slot overall.
    always_comb begin
        upperFound = 1'b0;
        upperSel   = '0;
        lowerSel   = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (freeMask[k]) begin
                lowerSel = SEL_W'(k);
                if (SEL_W'(k) >= ptr_q) begin
                    upperFound = 1'b1;
                    upperSel   = SEL_W'(k);
                end
            end
        end
        selIdx = upperFound ? upperSel : lowerSel;
    end

    // Pointer moves just past the channel that took the item, wrapping
    // explicitly so non-power-of-two channel counts rotate correctly.
    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            ptr_d = (selIdx == SEL_W'(NUM_OUT - 1)) ? '0 : selIdx + 1'b1;
        end
    end

    // Per-channel occupancy: a load wins over a drain in the same cycle,
    // otherwise an accepted output empties the slot.
    always_comb begin
        full_d = full_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            slotData_d[k] = slotData_q[k];
            if (fire && (selIdx == SEL_W'(k))) begin
                full_d[k]     = 1'b1;
                slotData_d[k] = data_i;
            end else if (full_q[k] && ready_i[k]) begin
                full_d[k] = 1'b0;
            end
        end
    end

    // State registers; reset discards every buffered item immediately.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            full_q <= '0;
            ptr_q  <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                slotData_q[k] <= '0;
            end
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                slotData_q[k] <= slotData_d[k];
            end
        end
    end

    // Flatten the per-channel registers onto the output bus.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            data_o[k*DATA_WIDTH +: DATA_WIDTH] = slotData_q[k];
        end
    end

endmodule

// File: tb/tb_round_robin_dispatcher.sv
// Directed bench for round_robin_dispatcher: a 4-channel instance covers
// reset, rotation, skipping, full/replace, allow gating and mid-stream
// reset; a 3-channel instance covers non-power-of-two wrap.
module tb_round_robin_dispatcher;

    logic        clk = 1'b0;
    logic        arst;
    logic        allow;
    logic        valid;
    logic [7:0]  dataIn;

    logic [3:0]  readyIn4;
    logic        readyOut4;
    logic [1:0]  sel4;
    logic [31:0] dataOut4;
    logic [3:0]  validOut4;

    logic [2:0]  readyIn3;
    logic        readyOut3;
    logic [1:0]  sel3;
    logic [23:0] dataOut3;
    logic [2:0]  validOut3;

    int nChecks = 0;
    int nFails  = 0;

    logic [1:0] skipSel [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [1:0] fullSel [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [1:0] resetSel [3] = '{2'd0, 2'd1, 2'd2};

    round_robin_dispatcher #(.NUM_OUT(4), .DATA_WIDTH(8)) dut4 (
        .clk_i   (clk),
        .arst_i  (arst),
        .allow_i (allow),
        .data_i  (dataIn),
        .valid_i (valid),
        .ready_o (readyOut4),
        .sel_o   (sel4),
        .data_o  (dataOut4),
        .valid_o (validOut4),
        .ready_i (readyIn4)
    );

    round_robin_dispatcher #(.NUM_OUT(3), .DATA_WIDTH(8)) dut3 (
        .clk_i   (clk),
        .arst_i  (arst),
        .allow_i (allow),
        .data_i  (dataIn),
        .valid_i (valid),
        .ready_o (readyOut3),
        .sel_o   (sel3),
        .data_o  (dataOut3),
        .valid_o (validOut3),
        .ready_i (readyIn3)
    );

    always #5 clk = ~clk;

    // Drive the shared inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic a, input logic v,
                                 input logic [7:0] d, input logic [3:0] r);
        allow    = a;
        valid    = v;
        dataIn   = d;
        readyIn4 = r;
        #1;
    endtask

    // One comparison point: count it, and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Directed sequence, stepping on falling edges so all sampling is
    // half a period away from the rising edge.
    initial begin
        arst     = 1'b1;
        allow    = 1'b0;
        valid    = 1'b0;
        dataIn   = 8'h00;
        readyIn4 = 4'h0;
        readyIn3 = 3'b000;
        #2;
        checkOutput("reset_valid", 32'(validOut4), 32'h0);
        checkOutput("reset_data", dataOut4, 32'h0);
        checkOutput("reset_ready_allow0", 32'(readyOut4), 32'h0);
        allow = 1'b1;
        #1;
        checkOutput("reset_ready_allow1", 32'(readyOut4), 32'h1);

        @(negedge clk);
        arst     = 1'b0;
        readyIn3 = 3'b111;

        $display("[TB] round-robin stream");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 4'hF);
            checkOutput($sformatf("rr4_ready_%0d", i), 32'(readyOut4), 32'h1);
            checkOutput($sformatf("rr4_sel_%0d", i), 32'(sel4), 32'(i % 4));
            checkOutput($sformatf("rr3_ready_%0d", i), 32'(readyOut3), 32'h1);
            checkOutput($sformatf("rr3_sel_%0d", i), 32'(sel3), 32'(i % 3));
            @(negedge clk);
            checkOutput($sformatf("rr4_valid_%0d", i), 32'(validOut4), 32'(1 << (i % 4)));
            checkOutput($sformatf("rr4_data_%0d", i), 32'(dataOut4[(i % 4)*8 +: 8]), 32'(8'h10 + i));
            checkOutput($sformatf("rr3_valid_%0d", i), 32'(validOut3), 32'(1 << (i % 3)));
            checkOutput($sformatf("rr3_data_%0d", i), 32'(dataOut3[(i % 3)*8 +: 8]), 32'(8'h10 + i));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 4'hF);
        @(negedge clk);
        checkOutput("rr4_drained", 32'(validOut4), 32'h0);
        checkOutput("rr3_drained", 32'(validOut3), 32'h0);

        $display("[TB] skip a blocked channel");
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'hA0 + j), 4'b1101);
            checkOutput($sformatf("skip_ready_%0d", j), 32'(readyOut4), 32'h1);
            checkOutput($sformatf("skip_sel_%0d", j), 32'(sel4), 32'(skipSel[j]));
            @(negedge clk);
        end
        checkOutput("skip_valid", 32'(validOut4), 32'h6);
        checkOutput("skip_ch1_held", 32'(dataOut4[15:8]), 32'hA1);
        checkOutput("skip_ch2_data", 32'(dataOut4[23:16]), 32'hA5);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'hF);
        @(negedge clk);
        checkOutput("skip_drained", 32'(validOut4), 32'h0);

        $display("[TB] fill every channel");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'hB0 + j), 4'h0);
            checkOutput($sformatf("full_sel_%0d", j), 32'(sel4), 32'(fullSel[j]));
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b1, 8'hC2, 4'h0);
        checkOutput("full_ready", 32'(readyOut4), 32'h0);
        checkOutput("full_valid", 32'(validOut4), 32'hF);
        applyStimulus(1'b1, 1'b1, 8'hC2, 4'b0100);
        checkOutput("replace_ready", 32'(readyOut4), 32'h1);
        checkOutput("replace_sel", 32'(sel4), 32'h2);
        @(negedge clk);
        checkOutput("replace_valid", 32'(validOut4), 32'hF);
        checkOutput("replace_ch2", 32'(dataOut4[23:16]), 32'hC2);
        checkOutput("replace_ch3_kept", 32'(dataOut4[31:24]), 32'hB0);
        checkOutput("replace_ch0_kept", 32'(dataOut4[7:0]), 32'hB1);

        $display("[TB] allow gating");
        applyStimulus(1'b0, 1'b1, 8'hD0, 4'hF);
        checkOutput("allow0_ready_full", 32'(readyOut4), 32'h0);
        @(negedge clk);
        checkOutput("allow0_drain", 32'(validOut4), 32'h0);
        applyStimulus(1'b0, 1'b1, 8'hD0, 4'hF);
        checkOutput("allow0_ready_empty", 32'(readyOut4), 32'h0);
        @(negedge clk);
        checkOutput("allow0_no_load", 32'(validOut4), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'hD0, 4'hF);
        checkOutput("allow1_ready", 32'(readyOut4), 32'h1);
        checkOutput("allow1_sel_frozen", 32'(sel4), 32'h3);
        @(negedge clk);
        checkOutput("allow1_valid", 32'(validOut4), 32'h8);
        checkOutput("allow1_data", 32'(dataOut4[31:24]), 32'hD0);

        $display("[TB] reset in mid-stream");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'hE0 + j), 4'b1000);
            checkOutput($sformatf("mid_sel_%0d", j), 32'(sel4), 32'(resetSel[j]));
            @(negedge clk);
        end
        checkOutput("mid_valid_before", 32'(validOut4), 32'h7);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'h0);
        arst = 1'b1;
        #1;
        checkOutput("mid_reset_valid", 32'(validOut4), 32'h0);
        checkOutput("mid_reset_data", dataOut4, 32'h0);
        arst = 1'b0;
        #1;
        applyStimulus(1'b1, 1'b1, 8'hF0, 4'h0);
        checkOutput("post_reset_ready", 32'(readyOut4), 32'h1);
        checkOutput("post_reset_sel", 32'(sel4), 32'h0);
        @(negedge clk);
        checkOutput("post_reset_valid", 32'(validOut4), 32'h1);
        checkOutput("post_reset_data", 32'(dataOut4[7:0]), 32'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
